// File: rtl/stringreco_pkg.sv
// Shared definitions for the serial string recogniser: state encoding and
// default sizing of the pattern and match counter.
package stringreco_pkg;

  localparam int DEF_PAT_W   = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 14;
  localparam int DEF_CNT_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10,
    ST_OFF  = 2'b11
  } state_e;

endpackage

// File: rtl/stringreco_stream_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags count==CNT_MAX.
// Shared with the display counters, hence its generic port names.
module sat_counter #(
  parameter int CNT_W   = 14,
  parameter int CNT_MAX = 9999
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == LP_MAX);

  // NOTE: async reset sits in the sensitivity list; state updates use <= so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;
  assign sat   = w_at_max;

endmodule

// File: rtl/stringreco_stream.sv
// Runtime-programmable serial pattern recogniser: shifts one bit per en strobe,
// compares the newest len_q bits with the pattern and counts (overlapping or not).
module stringreco_stream
  import stringreco_pkg::*;
#(
  parameter int PAT_W   = DEF_PAT_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CNT_MAX = DEF_CNT_MAX
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             ovl,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] count,
  output logic             hit,
  output logic             sat,
  output logic [1:0]       state
);

  localparam logic [LEN_W-1:0] LP_PAT_W = LEN_W'(PAT_W);

  state_e           r_state;
  state_e           w_state_nxt;
  // Only PAT_W-1 past bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0] r_hist;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic             r_hit;

  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_fill_inc;
  logic [LEN_W-1:0] w_fill_nxt;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_consume;
  logic             w_cmp_eq;
  logic             w_match;

  // load wins over en: a bit strobed together with load is dropped.
  assign w_consume = en && !load && (r_state == ST_FILL || r_state == ST_RUN);
  assign w_window  = {r_hist, din};

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_cmp_eq      = (((w_window ^ r_pat) & w_mask) == '0);
  assign w_fill_inc    = r_fill + LEN_W'(1);
  assign w_match       = w_consume && (w_fill_inc >= r_len) && w_cmp_eq;
  assign w_len_clamped = (pat_len > LP_PAT_W) ? LP_PAT_W : pat_len;

  always_comb begin
    if (w_match && !r_ovl) begin
      w_fill_nxt = '0;
    end else if (w_fill_inc > LP_PAT_W) begin
      w_fill_nxt = LP_PAT_W;
    end else begin
      w_fill_nxt = w_fill_inc;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = (pat_len == '0) ? ST_OFF : ST_FILL;
    end else if (w_consume) begin
      if (w_fill_nxt >= r_len || r_len == LEN_W'(1)) begin
        w_state_nxt = ST_RUN;
      end else begin
        w_state_nxt = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hist <= '0;
      r_pat  <= '0;
      r_fill <= '0;
      r_len  <= '0;
      r_ovl  <= 1'b0;
      r_hit  <= 1'b0;
    end else if (load) begin
      r_hist <= '0;
      r_pat  <= pattern;
      r_fill <= '0;
      r_len  <= w_len_clamped;
      r_ovl  <= ovl;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= w_match;
      if (w_consume) begin
        r_hist <= w_window[PAT_W-2:0];
        r_fill <= w_fill_nxt;
      end
    end
  end

  sat_counter #(
    .CNT_W  (CNT_W),
    .CNT_MAX(CNT_MAX)
  ) u_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .clr  (load),
    .inc  (w_match),
    .count(count),
    .sat  (sat)
  );

  assign hit   = r_hit;
  assign state = r_state;

endmodule
